pipelined_multiplier_hs: RTL and testbench
==========================================

PIPELINED_MULTIPLIER_HS -- requirements
Module: pipelined_multiplier_hs

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 8, operand width in bits, legal minimum 2.
- STAGES, 3, pipeline register stages, legal minimum 1.
- TAG_W, 4, width of the sideband tag carried alongside each operation, legal minimum 1.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operand pair and mode present.
- in_ready, output, 1, block can accept an operation this cycle.
- a, input, WIDTH, multiplicand.
- b, input, WIDTH, multiplier.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned.
- in_tag, input, TAG_W, sideband tag for the operation.
- out_valid, output, 1, product present.
- out_ready, input, 1, downstream accepts the product.
- product, output, 2*WIDTH, result.
- out_tag, output, TAG_W, tag of the presented result.
- occupancy, output, clog2(STAGES+1), number of valid operations in flight.

Function
REQ-003 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; a, b, signed_mode and in_tag are sampled on that edge.
REQ-004 product SHALL equal the exact 2*WIDTH-bit product: a*b unsigned when signed_mode=0, and the two's-complement product when signed_mode=1, with no truncation or saturation.
REQ-005 Pipeline behaviour:
- The pipeline SHALL consist of STAGES stages, each with its own valid bit.
- An operation accepted on edge N with no backpressure SHALL present out_valid=1 with its product during the cycle after edge N+STAGES-1.
- Latency SHALL therefore be STAGES edges, counting the capture edge.
REQ-006 out_tag SHALL be the in_tag of the operation currently presented, and results SHALL emerge in acceptance order.
REQ-007 Stage advance rule:
- Stage k SHALL advance when stage k+1 is empty or advancing.
- The last stage SHALL advance when out_valid=0 or out_ready=1.
- A bubble SHALL be absorbed by the stage behind it (bubble collapsing).
REQ-008 in_ready SHALL equal (stage 1 empty OR stage 1 advancing) AND NOT reset; a combinational path from out_ready to in_ready is permitted.
REQ-009 With in_valid and out_ready held at 1, throughput SHALL be one operation per cycle.
REQ-010 While out_valid=1 and out_ready=0, product, out_tag and out_valid SHALL hold stable until the transfer completes.
REQ-011 When the pipeline is full and the output is transferred on the same edge as a new acceptance, both SHALL occur and occupancy SHALL be unchanged.
REQ-012 occupancy update rule:
- occupancy SHALL increment on an accept without a transfer.
- It SHALL decrement on a transfer without an accept.
- It SHALL never exceed STAGES.
REQ-013 When occupancy=STAGES and out_ready=0, in_ready SHALL be 0.
REQ-014 Mode and tag SHALL travel per operation, so mixed signed and unsigned operations back-to-back yield independently correct results.

Reset
REQ-015 While reset=1 on a rising edge, all stage valid bits SHALL clear; out_valid=0, product=0, out_tag=0 and occupancy=0 SHALL hold after that edge.
REQ-016 in_ready SHALL be 0 during any cycle in which reset=1, and no operation SHALL be accepted on such an edge.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear at the output afterwards.
REQ-018 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=8, STAGES=3, TAG_W=4)
REQ-019 Latency check:
- Stimulus: unsigned a=10, b=5, tag=1 accepted on edge N, out_ready=1.
- Response: product=50 and out_tag=1 with out_valid=1 after edge N+2; out_valid=0 before that.
REQ-020 Mode check:
- Stimulus: back-to-back operations a=0xFF, b=0x02 with signed_mode=0, then the same with signed_mode=1, then signed a=-128, b=-128.
- Response: products 510, 0xFFFE and 16384, in order, on consecutive cycles.
REQ-021 Full-throughput check:
- Stimulus: 20 random operations on consecutive cycles with out_ready=1.
- Response: 20 results on consecutive cycles, all matching a reference model; in_ready=1 throughout.
REQ-022 Backpressure check:
- Stimulus: out_ready=0 with 5 operations offered.
- Response: exactly 3 accepted, then in_ready=0 and occupancy=3 with outputs stable.
- Then: releasing out_ready for one cycle transfers one result and accepts one new operation on the same edge.
REQ-023 Bubble check:
- Stimulus: in_valid pattern 1,0,1,0,1 with out_ready=0, then out_ready=1.
- Response: all 3 results emerge in order on consecutive cycles.
REQ-024 Reset mid-flight check:
- Stimulus: reset pulsed for one cycle while occupancy=2.
- Response: out_valid=0 and occupancy=0 after the reset edge; neither discarded result ever appears.

Source files
------------

// File: rtl/pipelined_multiplier_hs.sv
// Pipelined multiplier with valid/ready handshake on both sides.
// The full 2*WIDTH-bit product is formed on the capture edge and then
// travels with its tag through STAGES registered stages. Each stage has
// its own valid bit; empty stages absorb bubbles so a stalled output only
// blocks the input once every stage is occupied.
module pipelined_multiplier_hs #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             signed_mode,
  input  logic [TAG_W-1:0]                 in_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*WIDTH-1:0]               product,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int PW    = 2 * WIDTH;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] ld;
  logic [PW-1:0]     prod_q [STAGES];
  logic [PW-1:0]     prod_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              accept;
  logic              xfer;

  // Exact product: operands are widened to the result width (sign- or
  // zero-extended by mode) so the truncated signed product is exact.
  function automatic logic [PW-1:0] mul_full(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             sgn);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    logic signed [PW-1:0] p;
    xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    p  = xe * ye;
    return p;
  endfunction

  // Load enables: a stage may take new contents when it is empty or
  // everything downstream of it is moving; the last stage moves on out_ready.
  always_comb begin
    logic go;
    ld = '0;
    go = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go    = go | ~vld_q[k];
      ld[k] = go;
    end
  end

  assign in_ready  = ld[0] & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign xfer      = out_valid & out_ready;
  assign product   = out_valid ? prod_q[STAGES-1] : '0;
  assign out_tag   = out_valid ? tag_q[STAGES-1]  : '0;
  assign occupancy = occ_q;

  // Next-state: capture into stage 0, shift loaded stages, track occupancy.
  always_comb begin
    vld_d  = vld_q;
    prod_d = prod_q;
    tag_d  = tag_q;
    occ_d  = occ_q;
    // stage 0: capture boundary, product formed here
    if (ld[0]) begin
      vld_d[0]  = accept;
      prod_d[0] = mul_full(a, b, signed_mode);
      tag_d[0]  = in_tag;
    end
    // stages 1..STAGES-1: transport boundaries
    for (int k = 1; k < STAGES; k++) begin
      if (ld[k]) begin
        vld_d[k]  = vld_q[k-1];
        prod_d[k] = prod_q[k-1];
        tag_d[k]  = tag_q[k-1];
      end
    end
    if (accept && !xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (xfer && !accept) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Control state: valid bits and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  // Datapath registers: no reset, outputs are masked by the valid bit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      prod_q[k] <= prod_d[k];
      tag_q[k]  <= tag_d[k];
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_hs.sv
// Testbench for pipelined_multiplier_hs: directed latency, mode,
// throughput, backpressure, bubble and reset scenarios, with a queue-based
// reference model checking every transferred result.
module tb_pipelined_multiplier_hs;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                signed_mode;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [2*WIDTH-1:0]  product;
  logic [TAG_W-1:0]    out_tag;
  logic [1:0]          occupancy;

  always #5 clk = ~clk;

  pipelined_multiplier_hs #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .out_tag(out_tag), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  t;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
    longint xi, yi, p;
    if (s) begin
      xi = $signed(x);
      yi = $signed(y);
    end else begin
      xi = longint'(x);
      yi = longint'(y);
    end
    p = xi * yi;
    return p[15:0];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  logic        st_prev = 1'b0;
  logic [15:0] h_p;
  logic [3:0]  h_t;
  always @(negedge clk) begin
    if (reset) begin
      chk("rdy_in_reset", 32'(in_ready), 32'd0);
      q.delete();
    end else begin
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      if (st_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_prod", 32'(product), 32'(h_p));
        chk("stall_tag", 32'(out_tag), 32'(h_t));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("model_prod", 32'(product), 32'(q[0].p));
          chk("model_tag", 32'(out_tag), 32'(q[0].t));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back('{p: ref_mul(a, b, signed_mode), t: in_tag});
    end
    st_prev = !reset && out_valid && !out_ready;
    h_p = product;
    h_t = out_tag;
  end

  task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic s, input logic [3:0] t,
                       output logic rdy, output logic ov);
    in_valid = v; a = aa; b = bb; signed_mode = s; in_tag = t;
    @(negedge clk);
    rdy = in_ready;
    ov  = out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic r, o;
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, r, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, o;
    logic [7:0] ba [5];
    logic [7:0] bb [5];
    logic       bs [5];
    int         idx, acc;
    logic [4:0] vpat;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0; in_tag = '0;

    // Reset state
    drive(1'b1, 8'd3, 8'd4, 1'b0, 4'd2, r, o);
    chk("reset_rdy0", 32'(r), 32'd0);
    drive(1'b1, 8'd3, 8'd4, 1'b0, 4'd2, r, o);
    chk("reset_rdy1", 32'(r), 32'd0);
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_prod", 32'(product), 32'd0);
    chk("reset_tag", 32'(out_tag), 32'd0);
    chk("reset_occ", 32'(occupancy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, r, o);
    chk("post_reset_rdy", 32'(r), 32'd1);

    // Latency: 10*5 tag 1
    drive(1'b1, 8'd10, 8'd5, 1'b0, 4'd1, r, o);
    chk("lat_accept", 32'(r), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      @(negedge clk);
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_prod", 32'(product), 32'd50);
    chk("lat_tag", 32'(out_tag), 32'd1);
    @(posedge clk); #1;
    idle(3);

    // Mixed signed / unsigned back-to-back
    drive(1'b1, 8'hFF, 8'h02, 1'b0, 4'd3, r, o);
    drive(1'b1, 8'hFF, 8'h02, 1'b1, 4'd4, r, o);
    drive(1'b1, 8'h80, 8'h80, 1'b1, 4'd5, r, o);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mode_v0", 32'(out_valid), 32'd1);
    chk("mode_p0", 32'(product), 32'd510);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mode_v1", 32'(out_valid), 32'd1);
    chk("mode_p1", 32'(product), 32'hFFFE);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mode_v2", 32'(out_valid), 32'd1);
    chk("mode_p2", 32'(product), 32'd16384);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mode_drained", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Full throughput with random operands
    for (int s = 0; s < 24; s++) begin
      if (s < 20) begin
        drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), r, o);
        chk("tput_rdy", 32'(r), 32'd1);
      end else begin
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, r, o);
      end
      chk("tput_valid", 32'(o), 32'((s >= STAGES && s < 20 + STAGES) ? 1 : 0));
    end
    idle(2);

    // Backpressure: 5 offered with out_ready low
    for (int i = 0; i < 5; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bs[i] = 1'($urandom);
    end
    out_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, ba[idx], bb[idx], bs[idx], 4'(idx + 8), r, o);
      if (r) begin
        acc++;
        idx++;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    @(negedge clk);
    chk("bp_rdy_low", 32'(in_ready), 32'd0);
    chk("bp_occ_full", 32'(occupancy), 32'd3);
    chk("bp_head", 32'(product), 32'(ref_mul(ba[0], bb[0], bs[0])));
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, ba[idx], bb[idx], bs[idx], 4'(idx + 8), r, o);
    chk("bp_release_rdy", 32'(r), 32'd1);
    chk("bp_release_valid", 32'(o), 32'd1);
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_occ_kept", 32'(occupancy), 32'd3);
    chk("bp_next_head", 32'(product), 32'(ref_mul(ba[1], bb[1], bs[1])));
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);

    // Bubbles with output stalled, then drained
    out_ready = 1'b0; acc = 0;
    vpat = 5'b10101;
    for (int c = 0; c < 5; c++) begin
      drive(vpat[c], 8'($urandom), 8'($urandom), 1'($urandom), 4'(c + 1), r, o);
      if (vpat[c] && r) acc++;
    end
    chk("bub_accepted", 32'(acc), 32'd3);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, r, o);
      chk("bub_valid", 32'(o), 32'((c < 3) ? 1 : 0));
    end

    // Reset with two operations in flight
    out_ready = 1'b0;
    drive(1'b1, 8'd7, 8'd9, 1'b0, 4'd11, r, o);
    drive(1'b1, 8'd6, 8'd3, 1'b1, 4'd12, r, o);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_occ_before", 32'(occupancy), 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 8'd2, 8'd2, 1'b0, 4'd13, r, o);
    chk("rst_rdy", 32'(r), 32'd0);
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_after_rdy", 32'(in_ready), 32'd1);
    chk("rst_after_valid", 32'(out_valid), 32'd0);
    chk("rst_after_occ", 32'(occupancy), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, r, o);
      chk("rst_no_ghost", 32'(o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
